// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU op codes, opcode/funct constants and the
// combinational instruction decoder used by the ID/EX stage.
package mips_pkg;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 6'd27;
  localparam alu_op_t ALU_SUB = 6'd28;
  localparam alu_op_t ALU_SRL = 6'd29;
  localparam alu_op_t ALU_SLL = 6'd30;
  localparam alu_op_t ALU_XOR = 6'd31;
  localparam alu_op_t ALU_AND = 6'd32;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_AND = 6'h24;

  // Where each ALU operand comes from; SRC_NONE yields a zero operand.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RS,
    SRC_RT,
    SRC_IMM
  } src_sel_t;

  typedef struct packed {
    alu_op_t    op;
    logic [4:0] shamt;
    logic [4:0] dest;
    src_sel_t   sel1;
    src_sel_t   sel2;
    logic       regwrite;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.op       = ALU_ADD;
    d.shamt    = '0;
    d.dest     = '0;
    d.sel1     = SRC_NONE;
    d.sel2     = SRC_NONE;
    d.regwrite = 1'b0;
    d.illegal  = 1'b1;
    case (instr[31:26])
      OPC_RTYPE: begin
        d.dest    = instr[15:11];
        d.illegal = 1'b0;
        d.sel1    = SRC_RS;
        d.sel2    = SRC_RT;
        case (instr[5:0])
          FN_ADD: d.op = ALU_ADD;
          FN_SUB: d.op = ALU_SUB;
          FN_XOR: d.op = ALU_XOR;
          FN_AND: d.op = ALU_AND;
          FN_SRL, FN_SLL: begin
            // The ALU shifts Source1, so the shifted register rt goes there.
            d.op    = (instr[5:0] == FN_SRL) ? ALU_SRL : ALU_SLL;
            d.sel1  = SRC_RT;
            d.sel2  = SRC_NONE;
            d.shamt = instr[10:6];
          end
          default: begin
            d.illegal = 1'b1;
            d.dest    = '0;
            d.sel1    = SRC_NONE;
            d.sel2    = SRC_NONE;
          end
        endcase
      end
      OPC_ADDI: begin
        d.op      = ALU_ADD;
        d.dest    = instr[20:16];
        d.sel1    = SRC_RS;
        d.sel2    = SRC_IMM;
        d.illegal = 1'b0;
      end
      default: ;
    endcase
    d.regwrite = !d.illegal && (d.dest != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, which beats the supplied
// value; register 0 is never forwarded.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = reg_data;
    if (idx != '0 && exm_we && exm_rd == idx) begin
      data = exm_data;
    end else if (idx != '0 && wb_we && wb_rd == idx) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction, forwards operands and
// presents registered ALU inputs, with stall (hold + refresh) and flush.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          stall,
  input  logic          flush,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] Source1,
  output logic [DW-1:0] Source2,
  output logic [5:0]    operation,
  output logic [4:0]    shamt,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_illegal
);

  dec_t          dec;
  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] cap_src1;
  logic [DW-1:0] cap_src2;
  logic [RW-1:0] cap_idx1;
  logic [RW-1:0] cap_idx2;
  logic [RW-1:0] src1_idx;
  logic [RW-1:0] src2_idx;
  logic [DW-1:0] ref_src1;
  logic [DW-1:0] ref_src2;
  logic          fresh;

  assign dec     = decode(id_instr);
  assign rs_idx  = RW'(id_instr[25:21]);
  assign rt_idx  = RW'(id_instr[20:16]);
  assign imm_ext = {{(DW-16){id_instr[15]}}, id_instr[15:0]};

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx(rs_idx), .reg_data(id_rs_data),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx(rt_idx), .reg_data(id_rt_data),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rt_fwd)
  );

  // Held operands re-run forwarding on their stored index while stalled.
  fwd_mux #(.DW(DW), .RW(RW)) u_ref_src1 (
    .idx(src1_idx), .reg_data(Source1),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(ref_src1)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_ref_src2 (
    .idx(src2_idx), .reg_data(Source2),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(ref_src2)
  );

  // Stored index 0 marks "not refreshable" (immediates, unused operands).
  always_comb begin
    cap_src1 = '0;
    cap_idx1 = '0;
    cap_src2 = '0;
    cap_idx2 = '0;
    case (dec.sel1)
      SRC_RS: begin
        cap_src1 = rs_fwd;
        cap_idx1 = rs_idx;
      end
      SRC_RT: begin
        cap_src1 = rt_fwd;
        cap_idx1 = rt_idx;
      end
      default: ;
    endcase
    case (dec.sel2)
      SRC_RT: begin
        cap_src2 = rt_fwd;
        cap_idx2 = rt_idx;
      end
      SRC_IMM: cap_src2 = imm_ext;
      default: ;
    endcase
  end

  // fresh forces the first edge after reset to load even if stall is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Source1     <= '0;
      Source2     <= '0;
      operation   <= ALU_ADD;
      shamt       <= '0;
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_illegal  <= 1'b0;
      src1_idx    <= '0;
      src2_idx    <= '0;
      fresh       <= 1'b1;
    end else begin
      fresh <= 1'b0;
      if (flush) begin
        Source1     <= '0;
        Source2     <= '0;
        operation   <= ALU_ADD;
        shamt       <= '0;
        ex_valid    <= 1'b0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_illegal  <= 1'b0;
        src1_idx    <= '0;
        src2_idx    <= '0;
      end else if (stall && !fresh) begin
        Source1 <= ref_src1;
        Source2 <= ref_src2;
      end else begin
        Source1     <= cap_src1;
        Source2     <= cap_src2;
        operation   <= dec.op;
        shamt       <= dec.shamt;
        ex_valid    <= id_valid;
        ex_rd       <= RW'(dec.dest);
        ex_regwrite <= id_valid && dec.regwrite;
        ex_illegal  <= id_valid && dec.illegal;
        src1_idx    <= cap_idx1;
        src2_idx    <= cap_idx2;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid = 1'b0;
  logic [31:0]   id_instr = '0;
  logic [DW-1:0] id_rs_data = '0;
  logic [DW-1:0] id_rt_data = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          exm_we = 1'b0;
  logic [RW-1:0] exm_rd = '0;
  logic [DW-1:0] exm_data = '0;
  logic          wb_we = 1'b0;
  logic [RW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic [DW-1:0] Source1;
  logic [DW-1:0] Source2;
  logic [5:0]    operation;
  logic [4:0]    shamt;
  logic          ex_valid;
  logic [RW-1:0] ex_rd;
  logic          ex_regwrite;
  logic          ex_illegal;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .stall(stall), .flush(flush),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .Source1(Source1), .Source2(Source2), .operation(operation), .shamt(shamt),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal)
  );

  int tests = 0;
  int fails = 0;

  // Expected EX contents plus the register numbers each operand came from
  // (0 = not a refreshable register operand).
  logic [31:0] m_s1, m_s2;
  int          m_op, m_sh, m_rd, m_r1, m_r2;
  bit          m_valid, m_rw, m_ill, m_fresh;

  int op_of_funct[int] = '{32: 27, 34: 28, 2: 29, 0: 30, 38: 31, 36: 32};
  int funct_list[6] = '{32, 34, 2, 0, 38, 36};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
    return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return (op << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
  endfunction

  function automatic logic [31:0] fwd(int r, logic [31:0] fallback);
    if (r != 0 && exm_we && int'(exm_rd) == r) return exm_data;
    if (r != 0 && wb_we && int'(wb_rd) == r) return wb_data;
    return fallback;
  endfunction

  function automatic void model_clear();
    m_s1 = 0; m_s2 = 0; m_op = 27; m_sh = 0; m_rd = 0;
    m_r1 = 0; m_r2 = 0; m_valid = 0; m_rw = 0; m_ill = 0;
  endfunction

  function automatic void model_load();
    int opc = int'(id_instr[31:26]);
    int fn  = int'(id_instr[5:0]);
    int rs  = int'(id_instr[25:21]);
    int rt  = int'(id_instr[20:16]);
    model_clear();
    m_ill = 1;
    if (opc == 0 && op_of_funct.exists(fn)) begin
      m_ill = 0;
      m_op  = op_of_funct[fn];
      m_rd  = int'(id_instr[15:11]);
      if (m_op == 29 || m_op == 30) begin
        m_s1 = fwd(rt, id_rt_data); m_r1 = rt;
        m_sh = int'(id_instr[10:6]);
      end else begin
        m_s1 = fwd(rs, id_rs_data); m_r1 = rs;
        m_s2 = fwd(rt, id_rt_data); m_r2 = rt;
      end
    end else if (opc == 8) begin
      m_ill = 0;
      m_rd  = rt;
      m_s1  = fwd(rs, id_rs_data); m_r1 = rs;
      m_s2  = 32'($signed(id_instr[15:0]));
    end
    m_rw    = !m_ill && m_rd != 0;
    m_valid = id_valid;
    if (!id_valid) begin
      m_rw = 0;
      m_ill = 0;
    end
  endfunction

  function automatic void model_step();
    if (flush) model_clear();
    else if (stall && !m_fresh) begin
      if (m_r1 != 0) m_s1 = fwd(m_r1, m_s1);
      if (m_r2 != 0) m_s2 = fwd(m_r2, m_s2);
    end else model_load();
    m_fresh = 0;
  endfunction

  task automatic checkAll();
    checkOutput("Source1", Source1, m_s1);
    checkOutput("Source2", Source2, m_s2);
    checkOutput("operation", 32'(operation), 32'(m_op));
    checkOutput("shamt", 32'(shamt), 32'(m_sh));
    checkOutput("ex_valid", 32'(ex_valid), 32'(m_valid));
    checkOutput("ex_rd", 32'(ex_rd), 32'(m_rd));
    checkOutput("ex_regwrite", 32'(ex_regwrite), 32'(m_rw));
    checkOutput("ex_illegal", 32'(ex_illegal), 32'(m_ill));
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic stl, input logic fl);
    id_instr = instr; id_valid = valid; id_rs_data = rsd; id_rt_data = rtd;
    stall = stl; flush = fl;
  endtask

  task automatic setFwd(input logic ew, input int er, input logic [31:0] ed,
                        input logic ww, input int wr, input logic [31:0] wd);
    exm_we = ew; exm_rd = RW'(er); exm_data = ed;
    wb_we = ww; wb_rd = RW'(wr); wb_data = wd;
  endtask

  task automatic stepCycle();
    model_step();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Reset is asserted and released between clock edges.
  task automatic doReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    m_fresh = 1;
    checkOutput("reset_operation", 32'(operation), 32'd27);
    checkAll();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    m_fresh = 1;
    doReset();

    applyStimulus(rtype(1, 2, 3, 0, 32), 1, 5, 7, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("add_src1", Source1, 32'd5);
    checkOutput("add_src2", Source2, 32'd7);
    checkOutput("add_rd", 32'(ex_rd), 32'd3);
    checkOutput("add_regwrite", 32'(ex_regwrite), 32'd1);

    applyStimulus(rtype(1, 2, 4, 0, 34), 1, 11, 22, 0, 0);
    setFwd(1, 1, 100, 1, 1, 50);
    stepCycle();
    checkOutput("prio_src1", Source1, 32'd100);
    checkOutput("prio_op", 32'(operation), 32'd28);

    applyStimulus(rtype(0, 2, 6, 0, 32), 1, 9, 3, 0, 0);
    setFwd(0, 0, 0, 1, 0, 50);
    stepCycle();
    checkOutput("r0_nofwd", Source1, 32'd9);

    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus(rtype(0, 9, 2, 4, 0), 1, 0, 1, 0, 0);
    stepCycle();
    checkOutput("sll_src1", Source1, 32'd1);
    checkOutput("sll_shamt", 32'(shamt), 32'd4);
    checkOutput("sll_op", 32'(operation), 32'd30);

    applyStimulus(itype(8, 0, 5, 16'hFFFF), 1, 0, 0, 0, 0);
    stepCycle();
    checkOutput("addi_src2", Source2, 32'hFFFF_FFFF);

    applyStimulus(rtype(6, 2, 7, 0, 32), 1, 32'h11, 32'h22, 0, 0);
    stepCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(rtype(3, 3, 3, 0, 34), 1, 1, 1, 1, 0);
      if (c == 1) setFwd(0, 0, 0, 1, 6, 32'hA);
      else setFwd(0, 0, 0, 0, 0, 0);
      stepCycle();
    end
    checkOutput("refresh_src1", Source1, 32'hA);
    checkOutput("refresh_src2", Source2, 32'h22);
    checkOutput("refresh_rd", 32'(ex_rd), 32'd7);

    applyStimulus(rtype(1, 2, 3, 0, 32), 1, 1, 2, 1, 1);
    stepCycle();
    checkOutput("flush_wins", 32'(ex_valid), 32'd0);

    applyStimulus(rtype(1, 2, 3, 0, 6'h27), 1, 1, 2, 0, 0);
    stepCycle();
    checkOutput("illegal_flag", 32'(ex_illegal), 32'd1);
    checkOutput("illegal_regwrite", 32'(ex_regwrite), 32'd0);

    applyStimulus(rtype(1, 2, 3, 0, 32), 1, 4, 4, 0, 0);
    stepCycle();
    applyStimulus(rtype(1, 2, 3, 0, 32), 1, 4, 4, 1, 0);
    stepCycle();
    doReset();
    applyStimulus(rtype(2, 1, 5, 0, 34), 1, 8, 9, 1, 0);
    stepCycle();
    checkOutput("post_reset_op", 32'(operation), 32'd28);
    checkOutput("post_reset_valid", 32'(ex_valid), 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] instr;
      int k = int'($urandom_range(0, 7));
      if (k < 6)
        instr = rtype(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), funct_list[k]);
      else if (k == 6)
        instr = itype(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
      else
        instr = $urandom;
      applyStimulus(instr, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      setFwd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It captures a decoded-stage instruction and its register operands on each clock, and resolves operand forwarding from the two later stages. It translates opcode/funct into the ALU operation codes and presents registered `Source1`, `Source2`, `operation` and `shamt` to the ALU, together with the writeback destination. Stall and flush inputs support hazard handling.

## Interface
Parameters:
- `DW`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_instr`  in  32  instruction word
- `id_rs_data`  in  DW  register-file read of rs
- `id_rt_data`  in  DW  register-file read of rt
- `stall`  in  1  hold current EX contents
- `flush`  in  1  squash current EX contents
- `exm_we`, `exm_rd`, `exm_data`  in  1/RW/DW  EX/MEM forwarding source
- `wb_we`, `wb_rd`, `wb_data`  in  1/RW/DW  MEM/WB forwarding source
- `Source1`, `Source2`  out  DW  ALU operands
- `operation`  out  6  ALU op code
- `shamt`  out  5  shift amount
- `ex_valid`  out  1  EX stage holds a valid instruction
- `ex_rd`  out  RW  writeback destination
- `ex_regwrite`  out  1  result is written back
- `ex_illegal`  out  1  unsupported instruction captured

## Operation
- Decode (combinational on `id_instr`):
  - For R-type (opcode 0x00), the funct field selects the op code:
    - 0x20 → 27 (add)
    - 0x22 → 28 (sub)
    - 0x02 → 29 (srl)
    - 0x00 → 30 (sll)
    - 0x26 → 31 (xor)
    - 0x24 → 32 (and)
  - For R-type, the destination is rd = instr[15:11].
  - For addi (opcode 0x08):
    - op 27
    - Source2 = sign-extended instr[15:0]
    - destination rt = instr[20:16]
  - Any other opcode/funct: `ex_illegal`=1, `ex_regwrite`=0, op 27, both operands 0.
- Shifts: `Source1` = forwarded rt value, `shamt` = instr[10:6]. The ALU shifts Source1. For non-shifts, `shamt`=0.
- `ex_regwrite` = 0 when the destination is register 0.
- Forwarding for each source register index r:
  - If r≠0 and `exm_we` and `exm_rd`==r: use `exm_data`.
  - Otherwise, if r≠0 and `wb_we` and `wb_rd`==r: use `wb_data`.
  - Otherwise: use the register-file value.
  - EX/MEM has priority over MEM/WB.
- Update priority per cycle: flush > stall > load.
  - flush: `ex_valid`←0, `ex_regwrite`←0, `ex_illegal`←0. Other outputs take their reset values.
  - stall: all outputs hold. Exception: a held operand whose source index matches an active forwarding source is refreshed with the forwarded data. Stored source indices are kept internally for this purpose.
  - load: capture the decode of `id_instr` and the forwarded operands; `ex_valid`←`id_valid`. When `id_valid`=0, `ex_regwrite`←0 and `ex_illegal`←0.
- An immediate operand is never refreshed by forwarding.

## Timing
- Latency: ID inputs are visible on outputs 1 cycle after the capturing edge.
- Reset (asynchronous, immediate): all outputs are 0, except `operation`=27.
  - With zero operands, the ALU then produces result 0 with zero=1.
- Reset asserted mid-stall discards held contents. The first edge after deassertion performs a normal load.
- When `flush` and `stall` are both asserted, flush wins.
- When both forwarding sources match with equal indices, EX/MEM wins.
- Outputs are registered only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg`:
  - ALU op-code constants (27–32)
  - opcode/funct constants
  - an `alu_op_t` 6-bit type
- One sub-module, `fwd_mux`: index compare + priority select. It is instantiated twice at capture and twice for the stall refresh.
- Decode is a combinational function in the package.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle → outputs immediately 0, `operation`=27. Release, then load add r3,r1,r2 (rs=5, rt=7) → next cycle `Source1`=5, `Source2`=7, op 27, `ex_rd`=3, `ex_regwrite`=1.
- Forward priority: sub r4,r1,r2 with `exm_rd`=1 data 100 and `wb_rd`=1 data 50 → `Source1`=100, op 28. Destination register 0 with `wb_rd`=0 → no forwarding.
- Shifts/immediates:
  - sll rd=2, rt=9 (value 1), shamt 4 → `Source1`=1, `shamt`=4, op 30.
  - addi r5,r0,0xFFFF → `Source2`=0xFFFFFFFF.
- Stall refresh: stall 3 cycles while holding add with rs=6. `wb_rd`=6 data 0xA in cycle 2 → `Source1` becomes 0xA. Other outputs are unchanged.
- Flush vs stall: both asserted → `ex_valid`=0 next cycle. Unsupported funct 0x27 loaded → `ex_illegal`=1, `ex_regwrite`=0.
